// File: rtl/cmm_row_reduce_buffer.sv
// Row reduce buffer: sums NUM_CH partial-sum rows lane-wise, offers the row on OUT, then
// streams requantised lanes on FEED. Define CMM_FEED_SAT_EN to saturate the feed instead of wrapping.
module cmm_row_reduce_buffer #(
  parameter int NUM_CH = 2,
  parameter int LANES  = 8,
  parameter int ACC_W  = 32,
  parameter int FEED_W = 16,
  parameter int SHIFT  = 8,
  parameter int ROWS   = 32,
  parameter int ROW_W  = $clog2(ROWS)
) (
  input  logic                          CLK,
  input  logic                          RSTN,
  input  logic                          CLR,
  input  logic                          IN_VALID,
  output logic                          IN_READY,
  input  logic [NUM_CH*LANES*ACC_W-1:0] IN_DATA,
  output logic                          OUT_VALID,
  input  logic                          OUT_READY,
  output logic [LANES*ACC_W-1:0]        OUT,
  output logic                          FEED_VALID,
  input  logic                          FEED_READY,
  output logic [FEED_W-1:0]             FEED_DATA,
  output logic                          FEED_LAST,
  output logic [ROW_W-1:0]              ROW_NUM,
  output logic                          DONE_ROW,
  output logic                          DONE
);

  localparam int CH_W   = $clog2(NUM_CH);
  localparam int SUM_W  = ACC_W + CH_W;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_HOLD = 2'd2,
    S_FEED = 2'd3
  } state_e;

  state_e                        state_q;
  logic [NUM_CH*LANES*ACC_W-1:0] in_q;
  logic signed [SUM_W-1:0]       sum_q [LANES];
  logic signed [SUM_W-1:0]       sum_d [LANES];
  logic [LANE_W-1:0]             lane_q;
  logic [ROW_W-1:0]              row_q;
  logic                          done_row_q;
  logic                          done_q;
  logic                          last_lane_s;

  // Shift the full-precision sum, then either clamp or wrap into FEED_W bits.
  function automatic logic [FEED_W-1:0] requant(input logic signed [SUM_W-1:0] v);
`ifdef CMM_FEED_SAT_EN
    logic signed [SUM_W-1:0] sh;
    sh = v >>> SHIFT;
    if (sh[SUM_W-1:FEED_W-1] != {(SUM_W-FEED_W+1){sh[SUM_W-1]}}) begin
      requant = sh[SUM_W-1] ? {1'b1, {(FEED_W-1){1'b0}}} : {1'b0, {(FEED_W-1){1'b1}}};
    end else begin
      requant = sh[FEED_W-1:0];
    end
`else
    requant = FEED_W'(v >>> SHIFT);
`endif
  endfunction

  // Lane-wise sum across channels with sign extension, so the sum never overflows.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      sum_d[l] = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        sum_d[l] = sum_d[l] + SUM_W'($signed(in_q[(c*LANES+l)*ACC_W +: ACC_W]));
      end
    end
  end

  assign last_lane_s = (lane_q == LANE_W'(LANES - 1));

  // Row FSM together with the capture, sum, lane, row and pulse registers.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q    <= S_IDLE;
      in_q       <= '0;
      for (int l = 0; l < LANES; l++) sum_q[l] <= '0;
      lane_q     <= '0;
      row_q      <= '0;
      done_row_q <= 1'b0;
      done_q     <= 1'b0;
    end else if (CLR) begin
      state_q    <= S_IDLE;
      in_q       <= '0;
      for (int l = 0; l < LANES; l++) sum_q[l] <= '0;
      lane_q     <= '0;
      row_q      <= '0;
      done_row_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_row_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (IN_VALID) begin
            in_q    <= IN_DATA;
            state_q <= S_ADD;
          end
        end
        S_ADD: begin
          for (int l = 0; l < LANES; l++) sum_q[l] <= sum_d[l];
          state_q <= S_HOLD;
        end
        S_HOLD: begin
          if (OUT_READY) begin
            done_row_q <= 1'b1;
            lane_q     <= '0;
            state_q    <= S_FEED;
          end
        end
        S_FEED: begin
          if (FEED_READY) begin
            if (last_lane_s) begin
              lane_q  <= '0;
              state_q <= S_IDLE;
              done_q  <= (row_q == ROW_W'(ROWS - 1));
              row_q   <= (row_q == ROW_W'(ROWS - 1)) ? '0 : row_q + ROW_W'(1);
            end else begin
              lane_q <= lane_q + LANE_W'(1);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // OUT exposes the wrapped low ACC_W bits of each lane sum.
  always_comb begin
    OUT = '0;
    for (int l = 0; l < LANES; l++) OUT[l*ACC_W +: ACC_W] = sum_q[l][ACC_W-1:0];
  end

  assign IN_READY   = (state_q == S_IDLE);
  assign OUT_VALID  = (state_q == S_HOLD);
  assign FEED_VALID = (state_q == S_FEED);
  assign FEED_LAST  = (state_q == S_FEED) && last_lane_s;
  assign FEED_DATA  = requant(sum_q[lane_q]);
  assign ROW_NUM    = row_q;
  assign DONE_ROW   = done_row_q;
  assign DONE       = done_q;

endmodule

// File: tb/tb_cmm_row_reduce_buffer.sv
// Directed bench for cmm_row_reduce_buffer: table of lane-0 requant/overflow rows plus
// hand sequences for latency, backpressure, row wrap, CLR and async reset.
module tb_cmm_row_reduce_buffer;
  localparam int NUM_CH = 2;
  localparam int LANES  = 8;
  localparam int ACC_W  = 32;
  localparam int FEED_W = 16;
  localparam int ROWS   = 4;
  localparam int ROW_W  = 2;

  logic                          clk = 1'b0;
  logic                          rst_n, clr, in_valid, in_ready;
  logic [NUM_CH*LANES*ACC_W-1:0] in_data;
  logic                          out_valid, out_ready;
  logic [LANES*ACC_W-1:0]        out_data;
  logic                          feed_valid, feed_ready, feed_last;
  logic [FEED_W-1:0]             feed_data;
  logic [ROW_W-1:0]              row_num;
  logic                          done_row, done;

  always #5 clk = ~clk;

  cmm_row_reduce_buffer #(.NUM_CH(NUM_CH), .LANES(LANES), .ACC_W(ACC_W), .FEED_W(FEED_W),
                          .SHIFT(8), .ROWS(ROWS), .ROW_W(ROW_W)) dut (
    .CLK(clk), .RSTN(rst_n), .CLR(clr), .IN_VALID(in_valid), .IN_READY(in_ready),
    .IN_DATA(in_data), .OUT_VALID(out_valid), .OUT_READY(out_ready), .OUT(out_data),
    .FEED_VALID(feed_valid), .FEED_READY(feed_ready), .FEED_DATA(feed_data),
    .FEED_LAST(feed_last), .ROW_NUM(row_num), .DONE_ROW(done_row), .DONE(done)
  );

  typedef struct {
    logic [31:0] c0;
    logic [31:0] c1;
    logic [31:0] out0;
    logic [15:0] feed_wrap;
    logic [15:0] feed_sat;
  } vec_t;

  vec_t                          tbl [6];
  int                            n_vec = 0;
  int                            n_bad = 0;
  int                            exp_row = 0;
  logic [31:0]                   c0_a [LANES];
  logic [31:0]                   c1_a [LANES];
  logic [31:0]                   exp_out_a [LANES];
  logic [15:0]                   exp_feed_a [LANES];
  logic [NUM_CH*LANES*ACC_W-1:0] row_d;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_main();
    for (int l = 0; l < LANES; l++) begin
      c0_a[l]       = 32'(256 * l);
      c1_a[l]       = 32'd256;
      exp_out_a[l]  = 32'(256 * (l + 1));
      exp_feed_a[l] = 16'(l + 1);
    end
  endtask

  task automatic set_tbl(input int i);
    for (int l = 0; l < LANES; l++) begin
      c0_a[l] = 32'd0; c1_a[l] = 32'd0; exp_out_a[l] = 32'd0; exp_feed_a[l] = 16'd0;
    end
    c0_a[0]      = tbl[i].c0;
    c1_a[0]      = tbl[i].c1;
    exp_out_a[0] = tbl[i].out0;
`ifdef CMM_FEED_SAT_EN
    exp_feed_a[0] = tbl[i].feed_sat;
`else
    exp_feed_a[0] = tbl[i].feed_wrap;
`endif
  endtask

  // Present one row, then check ADD (not yet valid) and HOLD (OUT valid) cycles.
  task automatic load();
    for (int l = 0; l < LANES; l++) begin
      row_d[l*ACC_W +: ACC_W]         = c0_a[l];
      row_d[(LANES+l)*ACC_W +: ACC_W] = c1_a[l];
    end
    chk("in_ready_idle", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_data  = row_d;
    tick();
    in_valid = 1'b0;
    in_data  = ~row_d;
    chk("add_out_valid", 64'(out_valid), 64'd0);
    chk("add_in_ready", 64'(in_ready), 64'd0);
    chk("done_width", 64'(done), 64'd0);
    tick();
    chk("hold_out_valid", 64'(out_valid), 64'd1);
    for (int l = 0; l < LANES; l++) chk("out_lane", 64'(out_data[l*ACC_W +: ACC_W]), 64'(exp_out_a[l]));
    chk("row_num", 64'(row_num), 64'(exp_row));
  endtask

  // Stall OUT for hold_wait cycles, accept, then drain the feed (optionally toggling ready).
  task automatic drain(input int hold_wait, input bit toggle);
    int beat;
    int cyc;
    for (int k = 0; k < hold_wait; k++) begin
      tick();
      chk("stall_out_valid", 64'(out_valid), 64'd1);
      chk("stall_out_lane0", 64'(out_data[ACC_W-1:0]), 64'(exp_out_a[0]));
      chk("stall_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("done_row", 64'(done_row), 64'd1);
    beat = 0;
    cyc  = 0;
    while (beat < LANES && cyc < 4 * LANES) begin
      feed_ready = toggle ? cyc[0] : 1'b1;
      chk("feed_valid", 64'(feed_valid), 64'd1);
      chk("feed_last", 64'(feed_last), 64'(beat == LANES - 1));
      if (cyc > 0) chk("done_row_width", 64'(done_row), 64'd0);
      if (feed_ready) begin
        chk("feed_data", 64'(feed_data), 64'(exp_feed_a[beat]));
        beat++;
      end
      tick();
      cyc++;
    end
    feed_ready = 1'b0;
    chk("feed_cycles", 64'(cyc), toggle ? 64'(2 * LANES) : 64'(LANES));
    chk("idle_in_ready", 64'(in_ready), 64'd1);
    chk("idle_feed_valid", 64'(feed_valid), 64'd0);
    chk("done", 64'(done), 64'(exp_row == ROWS - 1));
    exp_row = (exp_row + 1) % ROWS;
    chk("row_num_next", 64'(row_num), 64'(exp_row));
  endtask

  initial begin
    tbl[0] = '{32'h7FFF0000, 32'h00000000, 32'h7FFF0000, 16'hFF00, 16'h7FFF};
    tbl[1] = '{32'hFF000000, 32'h00000000, 32'hFF000000, 16'h0000, 16'h8000};
    tbl[2] = '{32'h7FFFFFFF, 32'h00000001, 32'h80000000, 16'h0000, 16'h7FFF};
    tbl[3] = '{32'h00001234, 32'h00000100, 32'h00001334, 16'h0013, 16'h0013};
    tbl[4] = '{32'hFFFFFF00, 32'hFFFFFF00, 32'hFFFFFE00, 16'hFFFE, 16'hFFFE};
    tbl[5] = '{32'h80000000, 32'h80000000, 32'h00000000, 16'h0000, 16'h8000};

    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0;
    out_ready = 1'b0; feed_ready = 1'b0;
    tick(); tick();
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_feed_valid", 64'(feed_valid), 64'd0);
    chk("rst_feed_last", 64'(feed_last), 64'd0);
    chk("rst_done_row", 64'(done_row), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_out", 64'(|out_data), 64'd0);
    chk("rst_feed_data", 64'(feed_data), 64'd0);
    chk("rst_row_num", 64'(row_num), 64'd0);
    rst_n = 1'b1;
    tick();

    set_main(); load(); drain(0, 1'b0);
    set_main(); load(); drain(5, 1'b1);
    for (int i = 0; i < 6; i++) begin
      set_tbl(i); load(); drain(0, 1'b0);
    end

    // CLR on the third feed beat of row 2.
    set_main(); load(); drain(0, 1'b0);
    set_main(); load(); drain(0, 1'b0);
    set_main(); load();
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    feed_ready = 1'b1; tick(); tick();
    chk("clr_beat3_data", 64'(feed_data), 64'd3);
    clr = 1'b1; tick(); clr = 1'b0; feed_ready = 1'b0;
    chk("clr_feed_valid", 64'(feed_valid), 64'd0);
    chk("clr_in_ready", 64'(in_ready), 64'd1);
    chk("clr_row_num", 64'(row_num), 64'd0);
    chk("clr_out", 64'(|out_data), 64'd0);
    chk("clr_feed_data", 64'(feed_data), 64'd0);
    chk("clr_done_row", 64'(done_row), 64'd0);
    exp_row = 0;

    // Asynchronous reset while row 1 sits in HOLD.
    set_main(); load(); drain(0, 1'b0);
    set_main(); load();
    #1 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    chk("arst_row_num", 64'(row_num), 64'd0);
    chk("arst_out", 64'(|out_data), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    exp_row = 0;
    set_main(); load(); drain(0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
